// File: rtl/gx4000_cart_sdram_writer.sv
// Buffers cartridge-loader byte writes in a small FIFO and drains them to SDRAM over req/ack.
// Optional macro GX4000_CART_CHECKSUM_EN adds a 16-bit running sum of accepted bytes.
module gx4000_cart_sdram_writer #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [24:0] ADDR_BASE  = 25'h0000000
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          cart_wr,
    input  logic [24:0]                   cart_addr,
    input  logic [7:0]                    cart_data,
    input  logic                          download,
    output logic                          sdram_req,
    output logic [24:0]                   sdram_addr,
    output logic [7:0]                    sdram_din,
    output logic                          sdram_we,
    input  logic                          sdram_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done
`ifdef GX4000_CART_CHECKSUM_EN
    ,
    output logic [15:0]                   checksum
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] remain;
    logic [1:0]    state_q, state_d;
    logic          dl_q;
    logic          ovf_q, ovf_d;
    logic          req_q, req_d;
    logic [24:0]   addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          pop, push, rise, fall;
    logic [32:0]   entry, head;

    always_comb begin
        pop    = req_q & sdram_ack;
        push   = cart_wr & ((level_q < DEPTH_L) | pop);
        entry  = {cart_addr + ADDR_BASE, cart_data};
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        remain  = level_q - LW'(pop);
        // An empty store after this cycle's pop means the head comes straight from the incoming write.
        head   = (remain == '0) ? entry : mem_q[rptr_d];
        req_d  = (level_d != '0);
        addr_d = req_d ? head[32:8] : addr_q;
        din_d  = req_d ? head[7:0]  : din_q;

        rise = download & ~dl_q;
        fall = ~download & dl_q;

        ovf_d = rise ? 1'b0 : ovf_q;
        if (cart_wr && !push)
            ovf_d = 1'b1;

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (rise) state_d = S_ACTIVE;
            S_ACTIVE: if (fall) state_d = S_DRAIN;
            S_DRAIN: begin
                if (rise)
                    state_d = S_ACTIVE;
                else if (level_q == '0 && !req_q)
                    state_d = S_DONE;
            end
            default:  state_d = rise ? S_ACTIVE : S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem_q[wptr_q] <= entry;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            state_q <= S_IDLE;
            dl_q    <= 1'b0;
            ovf_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            state_q <= state_d;
            dl_q    <= download;
            ovf_q   <= ovf_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

`ifdef GX4000_CART_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = rise ? 16'h0000 : sum_q;
        if (push)
            sum_d = sum_d + 16'(cart_data);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign checksum = sum_q;
`endif

    assign sdram_req  = req_q;
    assign sdram_we   = req_q;
    assign sdram_addr = addr_q;
    assign sdram_din  = din_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_gx4000_cart_sdram_writer.sv
// Directed bench for gx4000_cart_sdram_writer: vector table plus hand-written multi-cycle sequences.
module tb_gx4000_cart_sdram_writer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cart_wr;
    logic [24:0] cart_addr;
    logic [7:0]  cart_data;
    logic        download;
    logic        sdram_ack;
    logic        sdram_req, sdram_we, overflow, busy, done;
    logic [24:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic [3:0]  fifo_level;
    logic        w_req, w_we, w_ovf, w_busy, w_done;
    logic [24:0] w_addr;
    logic [7:0]  w_din;
    logic [3:0]  w_level;
`ifdef GX4000_CART_CHECKSUM_EN
    logic [15:0] checksum, w_checksum;
`endif

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk_sys = ~clk_sys;

    gx4000_cart_sdram_writer #(.FIFO_DEPTH(8), .ADDR_BASE(25'h0000000)) dut (
        .clk_sys(clk_sys), .reset(reset), .cart_wr(cart_wr), .cart_addr(cart_addr),
        .cart_data(cart_data), .download(download), .sdram_req(sdram_req),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we),
        .sdram_ack(sdram_ack), .fifo_level(fifo_level), .overflow(overflow),
        .busy(busy), .done(done)
`ifdef GX4000_CART_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    gx4000_cart_sdram_writer #(.FIFO_DEPTH(8), .ADDR_BASE(25'h1FFFFFF)) dut_w (
        .clk_sys(clk_sys), .reset(reset), .cart_wr(cart_wr), .cart_addr(cart_addr),
        .cart_data(cart_data), .download(download), .sdram_req(w_req),
        .sdram_addr(w_addr), .sdram_din(w_din), .sdram_we(w_we),
        .sdram_ack(sdram_ack), .fifo_level(w_level), .overflow(w_ovf),
        .busy(w_busy), .done(w_done)
`ifdef GX4000_CART_CHECKSUM_EN
        , .checksum(w_checksum)
`endif
    );

    typedef struct {
        logic        dl, wr, ack;
        logic [24:0] addr;
        logic [7:0]  data;
        logic        req;
        logic [24:0] eaddr;
        logic [7:0]  edin;
        logic [3:0]  lvl;
        logic        ovf, bsy, dn;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic dl, input logic wr, input logic ack,
                                input logic [24:0] a, input logic [7:0] d,
                                input logic rq, input logic [24:0] ea, input logic [7:0] ed,
                                input logic [3:0] lv, input logic ov, input logic bz, input logic dn);
        vec_t v;
        v.dl = dl; v.wr = wr; v.ack = ack; v.addr = a; v.data = d;
        v.req = rq; v.eaddr = ea; v.edin = ed; v.lvl = lv; v.ovf = ov; v.bsy = bz; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; cart_wr = 1'b0; cart_addr = '0; cart_data = '0;
        download = 1'b0; sdram_ack = 1'b0;

        vt[0]  = mk(1,0,1, 25'h0,   8'h00, 0, 25'h0,   8'h00, 0, 0,1,0);
        vt[1]  = mk(1,1,1, 25'h100, 8'hA5, 1, 25'h100, 8'hA5, 1, 0,1,0);
        vt[2]  = mk(1,0,1, 25'h0,   8'h00, 0, 25'h100, 8'hA5, 0, 0,1,0);
        vt[3]  = mk(0,0,1, 25'h0,   8'h00, 0, 25'h100, 8'hA5, 0, 0,1,0);
        vt[4]  = mk(0,0,1, 25'h0,   8'h00, 0, 25'h100, 8'hA5, 0, 0,0,1);
        vt[5]  = mk(0,0,1, 25'h0,   8'h00, 0, 25'h100, 8'hA5, 0, 0,0,0);
        vt[6]  = mk(1,0,1, 25'h0,   8'h00, 0, 25'h100, 8'hA5, 0, 0,1,0);
        for (int i = 0; i < 8; i++)
            vt[7+i] = mk(1,1,1, 25'(i), 8'(8'h10 + i), 1, 25'(i), 8'(8'h10 + i), 1, 0,1,0);
        vt[15] = mk(1,0,1, 25'h0,   8'h00, 0, 25'h7,   8'h17, 0, 0,1,0);
        vt[16] = mk(0,0,1, 25'h0,   8'h00, 0, 25'h7,   8'h17, 0, 0,1,0);
        vt[17] = mk(0,0,1, 25'h0,   8'h00, 0, 25'h7,   8'h17, 0, 0,0,1);
        vt[18] = mk(0,0,1, 25'h0,   8'h00, 0, 25'h7,   8'h17, 0, 0,0,0);

        tick(); tick();
        chk("rst_req", {31'd0, sdram_req}, 32'd0);
        chk("rst_we", {31'd0, sdram_we}, 32'd0);
        chk("rst_addr", {7'd0, sdram_addr}, 32'd0);
        chk("rst_din", {24'd0, sdram_din}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_flags", {29'd0, overflow, busy, done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            download = vt[i].dl; cart_wr = vt[i].wr; sdram_ack = vt[i].ack;
            cart_addr = vt[i].addr; cart_data = vt[i].data;
            tick();
            chk($sformatf("v%0d_req", i), {30'd0, sdram_req, sdram_we}, {30'd0, vt[i].req, vt[i].req});
            chk($sformatf("v%0d_addr", i), {7'd0, sdram_addr}, {7'd0, vt[i].eaddr});
            chk($sformatf("v%0d_din", i), {24'd0, sdram_din}, {24'd0, vt[i].edin});
            chk($sformatf("v%0d_level", i), {28'd0, fifo_level}, {28'd0, vt[i].lvl});
            chk($sformatf("v%0d_flags", i), {29'd0, overflow, busy, done},
                {29'd0, vt[i].ovf, vt[i].bsy, vt[i].dn});
        end

        // Overflow: ack held low, nine writes into an eight-deep FIFO
        sdram_ack = 1'b0; cart_wr = 1'b0; download = 1'b1;
        tick();
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            cart_wr = 1'b1; cart_addr = 25'(25'h200 + k); cart_data = 8'(8'h30 + k);
            tick();
            chk($sformatf("ovf_w%0d_level", k), {28'd0, fifo_level}, (k < 8) ? k + 1 : 8);
            chk($sformatf("ovf_w%0d_flag", k), {31'd0, overflow}, (k == 8) ? 1 : 0);
            chk($sformatf("ovf_w%0d_head", k), {sdram_req, sdram_addr[14:0], 8'd0, sdram_din},
                {1'b1, 15'h200, 8'd0, 8'h30});
        end
        cart_wr = 1'b0;
        tick();
        chk("ovf_hold_level", {28'd0, fifo_level}, 32'd8);
        sdram_ack = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j < 7) begin
                chk($sformatf("ovf_d%0d_head", j), {sdram_req, sdram_addr[14:0], 8'd0, sdram_din},
                    {1'b1, 15'(15'h201 + j), 8'd0, 8'(8'h31 + j)});
            end else begin
                chk("ovf_d7_req", {31'd0, sdram_req}, 32'd0);
            end
            chk($sformatf("ovf_d%0d_level", j), {28'd0, fifo_level}, 7 - j);
        end
        tick();
        chk("ovf_no9th", {31'd0, sdram_req}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        download = 1'b0;
        wait_done("ovf_done");
        tick();
        chk("ovf_after_done", {30'd0, busy, done}, 32'd0);
        download = 1'b1;
        tick();
        chk("ovf_cleared", {30'd0, overflow, busy}, 32'd1);

        // Ack stall: presented entry stays put while ack is low
        sdram_ack = 1'b0;
        cart_wr = 1'b1; cart_addr = 25'h300; cart_data = 8'h40;
        tick();
        cart_addr = 25'h301; cart_data = 8'h41;
        tick();
        cart_wr = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("stall%0d", s), {sdram_req, sdram_addr[14:0], fifo_level, 4'd0, sdram_din},
                {1'b1, 15'h300, 4'd2, 4'd0, 8'h40});
        end
        sdram_ack = 1'b1;
        tick();
        chk("stall_pop", {sdram_req, sdram_addr[14:0], fifo_level, 4'd0, sdram_din},
            {1'b1, 15'h301, 4'd1, 4'd0, 8'h41});
        tick();
        chk("stall_empty", {27'd0, sdram_req, fifo_level}, 32'd0);

        // Base wrap and asynchronous reset with entries queued
        sdram_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cart_wr = 1'b1; cart_addr = 25'(2 + k); cart_data = 8'(8'h50 + k);
            tick();
            if (k == 0) begin
                chk("wrap_addr", {7'd0, w_addr}, 32'h0000001);
                chk("nowrap_addr", {7'd0, sdram_addr}, 32'h0000002);
            end
        end
        cart_wr = 1'b0;
        chk("rstq_level", {28'd0, fifo_level}, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("rstq_req", {30'd0, sdram_req, sdram_we}, 32'd0);
        chk("rstq_level0", {28'd0, fifo_level}, 32'd0);
        chk("rstq_busy", {31'd0, busy}, 32'd0);
        chk("rstq_addr", {7'd0, sdram_addr}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rstq_stay_idle", {27'd0, sdram_req, fifo_level}, 32'd0);

`ifdef GX4000_CART_CHECKSUM_EN
        download = 1'b0;
        tick(); tick(); tick(); tick();
        download = 1'b1; sdram_ack = 1'b1;
        tick();
        chk("cks_clear0", {16'd0, checksum}, 32'd0);
        for (int k = 0; k < 257; k++) begin
            cart_wr = 1'b1; cart_addr = 25'(k); cart_data = 8'hFF;
            tick();
        end
        cart_wr = 1'b0;
        tick();
        download = 1'b0;
        wait_done("cks_done");
        chk("cks_sum", {16'd0, checksum}, 32'h0000FFFF);
        tick();
        download = 1'b1;
        tick();
        chk("cks_restart", {16'd0, checksum}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
